// File: rtl/io_mmio_responder.sv
// io_mmio_responder: memory-mapped board I/O on the CPU's shared bus.
// Serves HEX/LED output registers, debounced KEY/SW inputs with sticky
// press flags, and an optional millisecond timer.
// Optional feature macro: IO_TIMER_EN (timer registers at F020-F028).
module io_mmio_responder #(
   parameter int DBITS      = 16,
   parameter int CLK_HZ     = 50000000,
   parameter int DEB_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [DBITS-1:0] ADDR,
   input  logic [DBITS-1:0] DIN,
   input  logic             WE,
   output logic [DBITS-1:0] DOUT,
   output logic             SEL,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   output logic [9:0]       LEDR,
   output logic [7:0]       LEDG,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1,
   output logic [6:0]       HEX2,
   output logic [6:0]       HEX3
);

   // Word addresses (byte address >> 2) of the mapped registers.
   localparam logic [DBITS-3:0] W_HEXV  = (DBITS-2)'(32'hF000 >> 2);
   localparam logic [DBITS-3:0] W_LEDRV = (DBITS-2)'(32'hF004 >> 2);
   localparam logic [DBITS-3:0] W_LEDGV = (DBITS-2)'(32'hF008 >> 2);
   localparam logic [DBITS-3:0] W_KDATA = (DBITS-2)'(32'hF010 >> 2);
   localparam logic [DBITS-3:0] W_KCTRL = (DBITS-2)'(32'hF014 >> 2);
   localparam logic [DBITS-3:0] W_SDATA = (DBITS-2)'(32'hF018 >> 2);
`ifdef IO_TIMER_EN
   localparam logic [DBITS-3:0] W_TCNT  = (DBITS-2)'(32'hF020 >> 2);
   localparam logic [DBITS-3:0] W_TLIM  = (DBITS-2)'(32'hF024 >> 2);
   localparam logic [DBITS-3:0] W_TCTRL = (DBITS-2)'(32'hF028 >> 2);
`endif

   // KEY and SW share one synchronizer/debouncer bank: bits [3:0] are KEY.
   localparam int NIN = 14;
   localparam logic [NIN-1:0] IN_RST = {10'b0, 4'hF};
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   function automatic logic [6:0] hex_font(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [DBITS-3:0] word;
   logic             unused_addr_lsbs;
   logic sel_hexv, sel_ledrv, sel_ledgv, sel_kdata, sel_kctrl, sel_sdata;
   logic sel_tcnt, sel_tlim, sel_tctrl;

   logic [DBITS-1:0] hexv_q, hexv_d;
   logic [9:0]       ledrv_q, ledrv_d;
   logic [7:0]       ledgv_q, ledgv_d;
   logic [3:0]       kctrl_q, kctrl_d;
   logic [3:0]       kfall;

   logic [NIN-1:0]   raw_in;
   logic [NIN-1:0]   sync1_q, sync2_q;
   logic [NIN-1:0]   deb_q, deb_d;
   logic [DEB_W-1:0] cnt_q [NIN];
   logic [DEB_W-1:0] cnt_d [NIN];

   assign word             = ADDR[DBITS-1:2];
   assign unused_addr_lsbs = ^ADDR[1:0];
   assign raw_in           = {SW, KEY};

   // Address decode: one select per mapped register.
   always_comb begin
      sel_hexv  = 1'b0;
      sel_ledrv = 1'b0;
      sel_ledgv = 1'b0;
      sel_kdata = 1'b0;
      sel_kctrl = 1'b0;
      sel_sdata = 1'b0;
      sel_tcnt  = 1'b0;
      sel_tlim  = 1'b0;
      sel_tctrl = 1'b0;
      case (word)
         W_HEXV:  sel_hexv  = 1'b1;
         W_LEDRV: sel_ledrv = 1'b1;
         W_LEDGV: sel_ledgv = 1'b1;
         W_KDATA: sel_kdata = 1'b1;
         W_KCTRL: sel_kctrl = 1'b1;
         W_SDATA: sel_sdata = 1'b1;
`ifdef IO_TIMER_EN
         W_TCNT:  sel_tcnt  = 1'b1;
         W_TLIM:  sel_tlim  = 1'b1;
         W_TCTRL: sel_tctrl = 1'b1;
`endif
         default: ;
      endcase
   end

   assign SEL = sel_hexv | sel_ledrv | sel_ledgv | sel_kdata | sel_kctrl |
                sel_sdata | sel_tcnt | sel_tlim | sel_tctrl;

`ifdef IO_TIMER_EN
   localparam int PRE_N = CLK_HZ / 1000;
   localparam int PRE_W = (PRE_N > 1) ? $clog2(PRE_N) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [15:0]      tcnt_q, tcnt_d, tlim_q, tlim_d;
   logic             rdy_q, rdy_d, ovr_q, ovr_d;
   logic             tick, wrap;
   logic [1:0]       tclr;

   // Timer next state: a CPU write to TCNT overrides the tick; set beats W1C.
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (WE && (sel_tcnt || sel_tlim)) pre_d = '0;
      wrap   = tick && !(WE && sel_tcnt) && (tlim_q != 16'd0) &&
               (tcnt_q == tlim_q - 16'd1);
      tcnt_d = tcnt_q;
      if (tick) tcnt_d = wrap ? 16'd0 : tcnt_q + 16'd1;
      if (WE && sel_tcnt) tcnt_d = DIN[15:0];
      tlim_d = (WE && sel_tlim) ? DIN[15:0] : tlim_q;
      tclr   = (WE && sel_tctrl) ? DIN[1:0] : 2'b00;
      rdy_d  = (rdy_q & ~tclr[0]) | wrap;
      ovr_d  = (ovr_q & ~tclr[1]) | (wrap & rdy_q);
   end

   // Timer state registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pre_q  <= '0;
         tcnt_q <= '0;
         tlim_q <= '0;
         rdy_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tcnt_q <= tcnt_d;
         tlim_q <= tlim_d;
         rdy_q  <= rdy_d;
         ovr_q  <= ovr_d;
      end
   end
`endif

   // Read mux: combinational so data is valid in the address cycle.
   always_comb begin
      DOUT = '0;
      if (sel_hexv)  DOUT = hexv_q;
      if (sel_ledrv) DOUT = DBITS'(ledrv_q);
      if (sel_ledgv) DOUT = DBITS'(ledgv_q);
      if (sel_kdata) DOUT = DBITS'(deb_q[3:0]);
      if (sel_kctrl) DOUT = DBITS'(kctrl_q);
      if (sel_sdata) DOUT = DBITS'(deb_q[13:4]);
`ifdef IO_TIMER_EN
      if (sel_tcnt)  DOUT = DBITS'(tcnt_q);
      if (sel_tlim)  DOUT = DBITS'(tlim_q);
      if (sel_tctrl) DOUT = DBITS'({ovr_q, rdy_q});
`endif
   end

   // Debounce: commit the synced value after DEB_CYCLES consecutive differences.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NIN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // CPU-writable registers; a new press flag beats a same-cycle W1C.
   always_comb begin
      hexv_d  = (WE && sel_hexv)  ? DIN       : hexv_q;
      ledrv_d = (WE && sel_ledrv) ? DIN[9:0]  : ledrv_q;
      ledgv_d = (WE && sel_ledgv) ? DIN[7:0]  : ledgv_q;
      kfall   = deb_q[3:0] & ~deb_d[3:0];
      kctrl_d = (kctrl_q & ~((WE && sel_kctrl) ? DIN[3:0] : 4'h0)) | kfall;
   end

   // Register update for CPU registers and the input path.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hexv_q  <= '0;
         ledrv_q <= '0;
         ledgv_q <= '0;
         kctrl_q <= '0;
         sync1_q <= IN_RST;
         sync2_q <= IN_RST;
         deb_q   <= IN_RST;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      end else begin
         hexv_q  <= hexv_d;
         ledrv_q <= ledrv_d;
         ledgv_q <= ledgv_d;
         kctrl_q <= kctrl_d;
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign LEDR = ledrv_q;
   assign LEDG = ledgv_q;
   assign HEX0 = hex_font(hexv_q[3:0]);
   assign HEX1 = hex_font(hexv_q[7:4]);
   assign HEX2 = hex_font(hexv_q[11:8]);
   assign HEX3 = hex_font(hexv_q[15:12]);

endmodule

// File: tb/tb_io_mmio_responder.sv
// Directed bench for io_mmio_responder (CLK_HZ=4000 -> 4 cycles/ms, DEB_CYCLES=3).
// Timer steps run only when IO_TIMER_EN is defined; otherwise F020 is checked as unmapped.
module tb_io_mmio_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] ADDR, DIN, DOUT;
   logic        WE, SEL;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [9:0]  LEDR;
   logic [7:0]  LEDG;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   int checks   = 0;
   int failures = 0;

   io_mmio_responder #(.DBITS(16), .CLK_HZ(4000), .DEB_CYCLES(3)) dut (
      .clk(clk), .resetn(resetn), .ADDR(ADDR), .DIN(DIN), .WE(WE),
      .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW), .LEDR(LEDR), .LEDG(LEDG),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      ADDR = a;
      DIN  = d;
      WE   = 1'b1;
      step(1);
      WE   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
      ADDR = a;
      #1;
      chk(tag, DOUT, exp);
   endtask

   initial begin
      resetn = 1'b0;
      WE     = 1'b0;
      ADDR   = 16'h0000;
      DIN    = 16'h0000;
      KEY    = 4'hF;
      SW     = 10'h000;
      step(3);
      resetn = 1'b1;
      step(1);

      // Reset state
      rd("rst_hexv", 16'hF000, 16'h0000);
      chk("rst_sel_hexv", SEL, 1);
      rd("rst_ledrv", 16'hF004, 16'h0000);
      chk("rst_sel_ledrv", SEL, 1);
      rd("rst_kdata", 16'hF010, 16'h000F);
      chk("rst_sel_kdata", SEL, 1);
      rd("rst_sdata", 16'hF018, 16'h0000);
      chk("rst_sel_sdata", SEL, 1);
      chk("rst_hex0", HEX0, 7'b1000000);
      chk("rst_hex1", HEX1, 7'b1000000);
      chk("rst_hex2", HEX2, 7'b1000000);
      chk("rst_hex3", HEX3, 7'b1000000);
      chk("rst_ledr", LEDR, 10'h000);
      chk("rst_ledg", LEDG, 8'h00);
      rd("unmapped_f030", 16'hF030, 16'h0000);
      chk("unmapped_f030_sel", SEL, 0);
      rd("plain_mem", 16'h0010, 16'h0000);
      chk("plain_mem_sel", SEL, 0);

      // Output registers and HEX font
      wr(16'hF000, 16'h1A2F);
      chk("hex3_1", HEX3, 7'b1111001);
      chk("hex2_A", HEX2, 7'b0001000);
      chk("hex1_2", HEX1, 7'b0100100);
      chk("hex0_F", HEX0, 7'b0001110);
      rd("hexv_rb", 16'hF000, 16'h1A2F);
      rd("hexv_lsb_ignored", 16'hF003, 16'h1A2F);
      wr(16'hF004, 16'hFFFF);
      chk("ledr_all", LEDR, 10'h3FF);
      rd("ledrv_rb", 16'hF004, 16'h03FF);
      wr(16'hF008, 16'h12A5);
      chk("ledg", LEDG, 8'hA5);
      rd("ledgv_rb", 16'hF008, 16'h00A5);
      wr(16'hF010, 16'h1234);
      rd("kdata_ro", 16'hF010, 16'h000F);
      wr(16'hF030, 16'hBEEF);
      rd("hexv_after_unmapped_wr", 16'hF000, 16'h1A2F);

      // SW debounce latency: visible on the 5th edge after the change
      SW = 10'h2A5;
      step(4);
      rd("sdata_not_yet", 16'hF018, 16'h0000);
      step(1);
      rd("sdata_settled", 16'hF018, 16'h02A5);

      // Short KEY[2] glitch is rejected
      KEY = 4'hB;
      step(2);
      KEY = 4'hF;
      step(6);
      rd("glitch_kdata", 16'hF010, 16'h000F);
      rd("glitch_kctrl", 16'hF014, 16'h0000);

      // Held KEY[2] press
      KEY = 4'hB;
      step(4);
      rd("press_kdata_early", 16'hF010, 16'h000F);
      step(1);
      rd("press_kdata", 16'hF010, 16'h000B);
      rd("press_kctrl", 16'hF014, 16'h0004);
      wr(16'hF014, 16'h0004);
      rd("kctrl_w1c", 16'hF014, 16'h0000);
      KEY = 4'hF;
      step(5);
      rd("release_kdata", 16'hF010, 16'h000F);
      rd("release_kctrl", 16'hF014, 16'h0000);

      // W1C collides with a new KEY[0] press: set wins
      KEY = 4'hE;
      step(4);
      wr(16'hF014, 16'h0001);
      rd("set_wins_kctrl", 16'hF014, 16'h0001);
      rd("set_wins_kdata", 16'hF010, 16'h000E);
      wr(16'hF014, 16'h0001);
      rd("kctrl_clear2", 16'hF014, 16'h0000);
      KEY = 4'hF;
      step(5);

`ifdef IO_TIMER_EN
      // Timer with TLIM=3
      wr(16'hF020, 16'h0000);
      wr(16'hF024, 16'h0003);
      rd("tlim_rb", 16'hF024, 16'h0003);
      rd("tcnt_0", 16'hF020, 16'h0000);
      step(3);
      rd("tcnt_before_tick", 16'hF020, 16'h0000);
      step(1);
      rd("tcnt_1", 16'hF020, 16'h0001);
      step(4);
      rd("tcnt_2", 16'hF020, 16'h0002);
      rd("tctrl_before_wrap", 16'hF028, 16'h0000);
      step(4);
      rd("tcnt_wrap", 16'hF020, 16'h0000);
      rd("tctrl_ready", 16'hF028, 16'h0001);
      step(12);
      rd("tcnt_wrap2", 16'hF020, 16'h0000);
      rd("tctrl_ovr", 16'hF028, 16'h0003);
      wr(16'hF028, 16'h0003);
      rd("tctrl_w1c", 16'hF028, 16'h0000);
      // TCNT write in a tick cycle wins
      step(2);
      wr(16'hF020, 16'h0005);
      rd("tcnt_write_wins", 16'hF020, 16'h0005);
      step(2);
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      rd("tcnt_after_rst", 16'hF020, 16'h0000);
      rd("tlim_after_rst", 16'hF024, 16'h0000);
      rd("tctrl_after_rst", 16'hF028, 16'h0000);
`else
      rd("timer_unmapped", 16'hF020, 16'h0000);
      chk("timer_unmapped_sel", SEL, 0);
      wr(16'hF024, 16'h1234);
      rd("tlim_unmapped", 16'hF024, 16'h0000);
      chk("tlim_unmapped_sel", SEL, 0);
`endif

      // Reset mid-debounce discards progress
      KEY = 4'h7;
      step(3);
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      rd("rst_mid_hexv", 16'hF000, 16'h0000);
      chk("rst_mid_hex0", HEX0, 7'b1000000);
      chk("rst_mid_ledr", LEDR, 10'h000);
      rd("rst_mid_sdata", 16'hF018, 16'h0000);
      step(4);
      rd("rst_mid_kdata_early", 16'hF010, 16'h000F);
      step(1);
      rd("rst_mid_kdata", 16'hF010, 16'h0007);
      rd("rst_mid_kctrl", 16'hF014, 16'h0008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
